ias_program_sequencer: RTL and testbench

- Instruction-issuing front end for the IAS core. It drives the core's opcode/address/data_in inputs and reads back its data_out.
- Holds a small program store of 24-bit instruction words, loaded over a write port. On start it walks the program from entry 0, issues each word to the core, waits a fixed execution window, and captures the core result.
- Stops on the HALT opcode, on the last store entry, or on abort.

---
 rtl/ias_program_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ias_program_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ias_program_sequencer.sv
// IAS core front end: walks a small program store and issues each
// instruction word to the core for a fixed execution window.
module ias_program_sequencer #(
    parameter int          PROG_DEPTH  = 16,
    parameter int          ADDR_W      = 4,
    parameter int          EXEC_CYCLES = 4,
    parameter logic [7:0]  HALT_OP     = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [23:0]       prog_wdata,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        core_data,
    output logic [7:0]        opcode,
    output logic [7:0]        address,
    output logic [7:0]        data_in,
    output logic              issue,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result,
    output logic [ADDR_W-1:0] pc_out,
    output logic [7:0]        instr_count
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_CAPTURE,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        result_q, result_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              issue_q, issue_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [23:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [23:0]       mem_q [PROG_DEPTH];
    logic              idle_like;
    logic              running;
    logic              mem_we;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign running   = !idle_like;
    assign mem_we    = reset && prog_we && idle_like;

    // Store is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_addr] <= prog_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        result_d = result_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        issue_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;

        if (abort && running) begin
            state_d = S_IDLE;
            op_d    = '0;
            addr_d  = '0;
            data_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc_d    = '0;
                        count_d = '0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    instr_d = mem_q[pc_q];
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (instr_q[23:16] == HALT_OP) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        op_d    = instr_q[23:16];
                        addr_d  = instr_q[15:8];
                        data_d  = instr_q[7:0];
                        issue_d = 1'b1;
                        cnt_d   = CNT_W'(EXEC_CYCLES - 1);
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Drop to NOP on leaving EXEC so the word is
                    // seen for exactly EXEC_CYCLES cycles.
                    if (cnt_q == '0) begin
                        op_d    = '0;
                        addr_d  = '0;
                        data_d  = '0;
                        state_d = S_CAPTURE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    result_d = core_data;
                    op_d     = '0;
                    addr_d   = '0;
                    data_d   = '0;
                    count_d  = count_q + 8'd1;
                    if (pc_q == ADDR_W'(PROG_DEPTH - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            count_q  <= '0;
            result_q <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            issue_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            instr_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            result_q <= result_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            issue_q  <= issue_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign opcode      = op_q;
    assign address     = addr_q;
    assign data_in     = data_q;
    assign issue       = issue_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign pc_out      = pc_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_ias_program_sequencer.sv
// Self-checking bench for ias_program_sequencer against a
// program-level reference model.
module tb_ias_program_sequencer;

    localparam int DEPTH = 16;
    localparam int EXEC  = 4;
    localparam int PER   = EXEC + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [23:0] prog_wdata = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  core_data = '0;
    logic [7:0]  opcode, address, data_in, result, instr_count;
    logic        issue, busy, done;
    logic [3:0]  pc_out;

    ias_program_sequencer #(
        .PROG_DEPTH(DEPTH), .ADDR_W(4),
        .EXEC_CYCLES(EXEC), .HALT_OP(8'hFF)
    ) dut (
        .clk(clk), .reset(reset),
        .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start),
        .abort(abort), .core_data(core_data),
        .opcode(opcode), .address(address),
        .data_in(data_in), .issue(issue),
        .busy(busy), .done(done), .result(result),
        .pc_out(pc_out), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] model_mem [DEPTH];
    logic [7:0]  model_result = '0;
    logic [7:0]  cd [DEPTH];

    int          n_iss, fin_cyc, extra_iss;
    int          iss_cyc [DEPTH+2];
    logic [23:0] iss_word [DEPTH+2];
    int          hold [DEPTH+2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [23:0] w);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = w;
        tick();
        prog_we = 1'b0;
        model_mem[a] = w;
    endtask

    task automatic rand_cd();
        for (int i = 0; i < DEPTH; i++) cd[i] = 8'($urandom);
    endtask

    // Start a program (optionally with a same-cycle write) and record
    // issue pulses, issued words, hold lengths and completion cycle.
    task automatic run_prog(input bit we, input logic [3:0] wa,
                            input logic [23:0] wd, input int budget);
        prog_we    = we;
        prog_addr  = wa;
        prog_wdata = wd;
        start      = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        if (we) model_mem[wa] = wd;
        n_iss   = 0;
        fin_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            if (issue) begin
                if (n_iss < DEPTH + 2) begin
                    iss_cyc[n_iss]  = c;
                    iss_word[n_iss] = {opcode, address, data_in};
                    hold[n_iss]     = 0;
                end
                core_data = cd[n_iss % DEPTH];
                n_iss++;
            end
            if (n_iss > 0 && n_iss <= DEPTH + 2) begin
                if ({opcode, address, data_in} == iss_word[n_iss-1] &&
                    c < iss_cyc[n_iss-1] + PER)
                    hold[n_iss-1]++;
            end
            if (done && !busy) begin
                fin_cyc = c;
                break;
            end
            tick();
        end
        extra_iss = 0;
        repeat (10) begin
            if (issue) extra_iss++;
            tick();
        end
    endtask

    // Compare the recorded run against the program-level model.
    task automatic verify_run();
        int n, exp_fin, lim;
        bit by_halt;
        logic [3:0] exp_pc;
        logic [7:0] exp_res;
        n = 0;
        by_halt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (model_mem[i][23:16] == 8'hFF) begin
                by_halt = 1'b1;
                break;
            end
            n++;
        end
        exp_fin = by_halt ? PER * n + 2 : PER * n;
        exp_pc  = by_halt ? 4'(n) : 4'(DEPTH - 1);
        exp_res = (n > 0) ? cd[n-1] : model_result;
        model_result = exp_res;

        checks++;
        if (n_iss !== n) begin
            errors++;
            $display("FAIL issue_count: got %0d expected %0d", n_iss, n);
        end
        lim = (n_iss < n) ? n_iss : n;
        for (int i = 0; i < lim; i++) begin
            checks++;
            if (iss_word[i] !== model_mem[i]) begin
                errors++;
                $display("FAIL issue_word[%0d]: got %h expected %h",
                         i, iss_word[i], model_mem[i]);
            end
            checks++;
            if (iss_cyc[i] !== 2 + PER * i) begin
                errors++;
                $display("FAIL issue_cycle[%0d]: got %0d expected %0d",
                         i, iss_cyc[i], 2 + PER * i);
            end
            checks++;
            if (hold[i] !== EXEC) begin
                errors++;
                $display("FAIL hold[%0d]: got %0d expected %0d",
                         i, hold[i], EXEC);
            end
        end
        checks++;
        if (fin_cyc !== exp_fin) begin
            errors++;
            $display("FAIL finish_cycle: got %0d expected %0d",
                     fin_cyc, exp_fin);
        end
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL done_busy: got %b expected 10", {done, busy});
        end
        checks++;
        if (instr_count !== 8'(n)) begin
            errors++;
            $display("FAIL instr_count: got %0d expected %0d",
                     instr_count, n);
        end
        checks++;
        if (pc_out !== exp_pc) begin
            errors++;
            $display("FAIL pc_out: got %0d expected %0d", pc_out, exp_pc);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL result: got %h expected %h", result, exp_res);
        end
        checks++;
        if (extra_iss !== 0) begin
            errors++;
            $display("FAIL extra_issue: got %0d expected 0", extra_iss);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        logic [51:0] obs;
        obs = {opcode, address, data_in, issue, busy, done,
               result, pc_out, instr_count};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s: got %h expected 0", tag, obs);
        end
    endtask

    task automatic test_reset();
        check_zero_outputs("reset_outputs");
    endtask

    task automatic test_basic();
        write_entry(4'd0, 24'h011005);
        write_entry(4'd1, 24'h021107);
        write_entry(4'd2, 24'hFF0000);
        rand_cd();
        cd[1] = 8'h0C;
        run_prog(1'b0, '0, '0, 200);
        verify_run();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (PER + 3) tick();
        checks++;
        if ({busy, opcode} !== {1'b1, 8'h02}) begin
            errors++;
            $display("FAIL mid_exec: got %h expected 102", {busy, opcode});
        end
        reset = 1'b0;
        tick();
        check_zero_outputs("reset_mid_outputs");
        reset = 1'b1;
        model_result = '0;
        rand_cd();
        run_prog(1'b0, '0, '0, 200);
        verify_run();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++)
            write_entry(4'(i), {8'h03, 16'($urandom)});
        rand_cd();
        run_prog(1'b0, '0, '0, 200);
        verify_run();
    endtask

    task automatic test_abort();
        logic [7:0] prev;
        prev  = result;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, done, issue, opcode, instr_count, pc_out} !== '0) begin
            errors++;
            $display("FAIL abort_state: got %h expected 0",
                     {busy, done, issue, opcode, instr_count, pc_out});
        end
        checks++;
        if (result !== prev) begin
            errors++;
            $display("FAIL abort_result: got %h expected %h", result, prev);
        end
        repeat (PER) tick();
        checks++;
        if ({busy, issue} !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: got %b expected 00", {busy, issue});
        end
    endtask

    task automatic test_busy_write();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = 24'h042009;
        tick();
        prog_we = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        rand_cd();
        run_prog(1'b0, '0, '0, 200);
        verify_run();
    endtask

    task automatic test_halted_write_start();
        rand_cd();
        run_prog(1'b1, 4'd0, 24'h053001, 200);
        checks++;
        if (iss_word[0] !== 24'h053001) begin
            errors++;
            $display("FAIL halted_write_first: got %h expected 053001",
                     iss_word[0]);
        end
        verify_run();
    endtask

    task automatic test_random();
        repeat (6) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [7:0] op;
                op = ($urandom_range(0, 5) == 0) ? 8'hFF
                                                 : 8'($urandom_range(1, 254));
                write_entry(4'(i), {op, 16'($urandom)});
            end
            rand_cd();
            run_prog(1'b0, '0, '0, 200);
            verify_run();
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_basic();
        test_reset_mid();
        test_fill();
        test_abort();
        test_busy_write();
        test_halted_write_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
